// File: rtl/seq_hit_monitor.sv
// Hit statistics for the 0110 detector output: saturating total, fixed-window
// count with sticky rate alarm, and the cycle distance between consecutive hits.
module seq_hit_monitor #(
    parameter int CNT_W  = 8,
    parameter int WIN    = 16,
    parameter int THRESH = 3,
    parameter int GAP_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hit,
    input  logic                       clr,
    output logic [CNT_W-1:0]           total_cnt,
    output logic [$clog2(WIN+1)-1:0]   win_cnt,
    output logic                       alarm,
    output logic [GAP_W-1:0]           last_gap,
    output logic                       gap_valid
);

    localparam int WC_W = $clog2(WIN+1);
    localparam int PW   = $clog2(WIN);
    // Gap counter stops one below all-ones so gap_cnt+1 never wraps.
    localparam logic [GAP_W-1:0] GAP_SAT = {{(GAP_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     win_pos_q, win_pos_d;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]  last_gap_q, last_gap_d;
    logic              gap_valid_q, gap_valid_d;
    logic              last_win;
    logic              alarm_hit;

    always_comb begin
        state_d     = state_q;
        win_pos_d   = win_pos_q;
        win_cnt_d   = win_cnt_q;
        total_d     = total_q;
        gap_cnt_d   = gap_cnt_q;
        last_gap_d  = last_gap_q;
        gap_valid_d = 1'b0;
        last_win    = (win_pos_q == PW'(WIN-1));
        alarm_hit   = (int'(win_cnt_q) + int'(hit)) >= THRESH;

        if (clr) begin
            state_d    = IDLE;
            win_pos_d  = '0;
            win_cnt_d  = '0;
            total_d    = '0;
            gap_cnt_d  = '0;
            last_gap_d = '0;
        end else begin
            win_pos_d = last_win ? '0 : win_pos_q + 1'b1;
            // A hit on the last window cycle only feeds this edge's alarm check.
            win_cnt_d = last_win ? '0 : win_cnt_q + WC_W'(hit);

            if (hit && total_q != {CNT_W{1'b1}})
                total_d = total_q + 1'b1;

            if (hit)
                gap_cnt_d = '0;
            else if (gap_cnt_q != GAP_SAT)
                gap_cnt_d = gap_cnt_q + 1'b1;

            if (hit && state_q != IDLE) begin
                last_gap_d  = gap_cnt_q + 1'b1;
                gap_valid_d = 1'b1;
            end

            case (state_q)
                IDLE:    if (alarm_hit) state_d = ALARM;
                         else if (hit)  state_d = TRACK;
                TRACK:   if (alarm_hit) state_d = ALARM;
                default: state_d = ALARM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            win_pos_q   <= '0;
            win_cnt_q   <= '0;
            total_q     <= '0;
            gap_cnt_q   <= '0;
            last_gap_q  <= '0;
            gap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_pos_q   <= win_pos_d;
            win_cnt_q   <= win_cnt_d;
            total_q     <= total_d;
            gap_cnt_q   <= gap_cnt_d;
            last_gap_q  <= last_gap_d;
            gap_valid_q <= gap_valid_d;
        end
    end

    assign total_cnt = total_q;
    assign win_cnt   = win_cnt_q;
    assign alarm     = (state_q == ALARM);
    assign last_gap  = last_gap_q;
    assign gap_valid = gap_valid_q;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Bench for seq_hit_monitor: directed scenarios plus random hits, checked
// against a model built from the list of hit cycles since the last reset/clr.
module tb_seq_hit_monitor;

    localparam int WIN    = 16;
    localparam int THRESH = 3;

    logic clk = 1'b0, reset = 1'b1, hit = 1'b0, clr = 1'b0;

    logic [7:0] tc_a; logic [4:0] wc_a; logic al_a; logic [7:0] lg_a; logic gv_a;
    logic [1:0] tc_b; logic [4:0] wc_b; logic al_b; logic [2:0] lg_b; logic gv_b;

    int checks = 0, failures = 0;

    // Model state: cycle index of every hit since reset/clr, and edges counted.
    int hits[$];
    int cyc = 0;

    seq_hit_monitor #(.CNT_W(8), .WIN(WIN), .THRESH(THRESH), .GAP_W(8)) dut_a (
        .clk(clk), .reset(reset), .hit(hit), .clr(clr),
        .total_cnt(tc_a), .win_cnt(wc_a), .alarm(al_a),
        .last_gap(lg_a), .gap_valid(gv_a));

    seq_hit_monitor #(.CNT_W(2), .WIN(WIN), .THRESH(THRESH), .GAP_W(3)) dut_b (
        .clk(clk), .reset(reset), .hit(hit), .clr(clr),
        .total_cnt(tc_b), .win_cnt(wc_b), .alarm(al_b),
        .last_gap(lg_b), .gap_valid(gv_b));

    always #5 clk = ~clk;

    function automatic int f_tot(input int maxv);
        return (hits.size() > maxv) ? maxv : hits.size();
    endfunction

    function automatic int f_win();
        int k, c;
        if (cyc == 0) return 0;
        k = cyc - 1;
        if (k % WIN == WIN-1) return 0;
        c = 0;
        foreach (hits[i]) if (hits[i] / WIN == k / WIN) c++;
        return c;
    endfunction

    function automatic int f_alarm();
        int c;
        foreach (hits[i]) begin
            c = 0;
            foreach (hits[j]) if (hits[j] / WIN == hits[i] / WIN) c++;
            if (c >= THRESH) return 1;
        end
        return 0;
    endfunction

    function automatic int f_gap(input int maxv);
        int d;
        if (hits.size() < 2) return 0;
        d = hits[hits.size()-1] - hits[hits.size()-2];
        return (d > maxv) ? maxv : d;
    endfunction

    function automatic int f_gv();
        return (hits.size() >= 2 && hits[hits.size()-1] == cyc-1) ? 1 : 0;
    endfunction

    // One clock with given inputs; outputs sampled 1 time unit after the edge.
    task automatic drive(input bit h, input bit c);
        hit = h; clr = c;
        @(posedge clk); #1;
        if (c) begin
            hits.delete(); cyc = 0;
        end else begin
            if (h) hits.push_back(cyc);
            cyc++;
        end
        hit = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) drive(1, 0);
        checks++; if (tc_a !== 8'd5) begin failures++; $display("FAIL pre_reset_total got=%0d exp=5", tc_a); end
        checks++; if (al_a !== 1'b1) begin failures++; $display("FAIL pre_reset_alarm got=%0d exp=1", al_a); end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({tc_a, wc_a, al_a, lg_a, gv_a, tc_b, wc_b, al_b, lg_b, gv_b} !== '0) begin
            failures++;
            $display("FAIL async_reset got a=%0d/%0d/%0d/%0d/%0d b=%0d/%0d/%0d/%0d/%0d exp=all 0",
                     tc_a, wc_a, al_a, lg_a, gv_a, tc_b, wc_b, al_b, lg_b, gv_b);
        end
        @(negedge clk) reset = 1'b0;
        hits.delete(); cyc = 0;
        for (int k = 0; k < 4; k++) drive(k == 3, 0);
        checks++; if (tc_a !== 8'd1) begin failures++; $display("FAIL reset_first_hit_total got=%0d exp=1", tc_a); end
        checks++; if (gv_a !== 1'b0) begin failures++; $display("FAIL reset_first_hit_gv got=%0d exp=0", gv_a); end
    endtask

    task automatic test_gap();
        drive(0, 1);
        for (int k = 0; k <= 15; k++) begin
            drive(k == 10 || k == 14 || k == 15, 0);
            if (k == 10) begin
                checks++; if (gv_a !== 1'b0) begin failures++; $display("FAIL gap_first_gv got=%0d exp=0", gv_a); end
            end
            if (k == 11) begin
                checks++; if (gv_a !== 1'b0) begin failures++; $display("FAIL gap_pulse_width got=%0d exp=0", gv_a); end
            end
            if (k == 14) begin
                checks++; if (lg_a !== 8'd4 || gv_a !== 1'b1) begin failures++; $display("FAIL gap_4 got=%0d/%0d exp=4/1", lg_a, gv_a); end
            end
            if (k == 15) begin
                checks++; if (lg_a !== 8'd1 || gv_a !== 1'b1) begin failures++; $display("FAIL gap_1 got=%0d/%0d exp=1/1", lg_a, gv_a); end
                checks++; if (tc_a !== 8'd3) begin failures++; $display("FAIL gap_total got=%0d exp=3", tc_a); end
            end
        end
    endtask

    task automatic test_alarm();
        drive(0, 1);
        for (int k = 0; k < 40; k++) begin
            drive(k == 2 || k == 6 || k == 10, 0);
            if (k == 2) begin
                checks++; if (wc_a !== 5'd1) begin failures++; $display("FAIL alarm_win1 got=%0d exp=1", wc_a); end
            end
            if (k == 6) begin
                checks++; if (wc_a !== 5'd2 || al_a !== 1'b0) begin failures++; $display("FAIL alarm_win2 got=%0d/%0d exp=2/0", wc_a, al_a); end
            end
            if (k >= 10 && al_a !== 1'b1) begin
                checks++; failures++; $display("FAIL alarm_sticky k=%0d got=%0d exp=1", k, al_a);
            end
        end
        checks++; if (al_a !== 1'b1) begin failures++; $display("FAIL alarm_persist got=%0d exp=1", al_a); end
        drive(0, 1);
        checks++; if (al_a !== 1'b0) begin failures++; $display("FAIL alarm_clr got=%0d exp=0", al_a); end
    endtask

    task automatic test_window();
        drive(0, 1);
        for (int k = 0; k <= 20; k++) begin
            drive(k == 13 || k == 15 || k == 16, 0);
            if (k == 15) begin
                checks++; if (wc_a !== 5'd0) begin failures++; $display("FAIL window_wrap got=%0d exp=0", wc_a); end
            end
            if (k == 16) begin
                checks++; if (wc_a !== 5'd1) begin failures++; $display("FAIL window_new got=%0d exp=1", wc_a); end
            end
            if (al_a !== 1'b0) begin
                checks++; failures++; $display("FAIL window_no_alarm k=%0d got=%0d exp=0", k, al_a);
            end
        end
        checks++; if (al_a !== 1'b0) begin failures++; $display("FAIL window_alarm_end got=%0d exp=0", al_a); end
    endtask

    task automatic test_boundary();
        drive(0, 1);
        for (int k = 0; k <= 16; k++) begin
            drive(k == 5 || k == 9 || k == 15, 0);
            if (k == 14) begin
                checks++; if (al_a !== 1'b0) begin failures++; $display("FAIL boundary_early got=%0d exp=0", al_a); end
            end
            if (k == 15) begin
                checks++; if (al_a !== 1'b1 || wc_a !== 5'd0) begin failures++; $display("FAIL boundary_alarm got=%0d/%0d exp=1/0", al_a, wc_a); end
            end
        end
    endtask

    task automatic test_saturation();
        drive(0, 1);
        for (int k = 0; k < 5; k++) drive(1, 0);
        checks++; if (tc_b !== 2'd3) begin failures++; $display("FAIL sat_total_small got=%0d exp=3", tc_b); end
        checks++; if (tc_a !== 8'd5) begin failures++; $display("FAIL sat_total_wide got=%0d exp=5", tc_a); end
        for (int k = 0; k < 19; k++) drive(0, 0);
        drive(1, 0);
        checks++; if (lg_b !== 3'd7 || gv_b !== 1'b1) begin failures++; $display("FAIL sat_gap_small got=%0d/%0d exp=7/1", lg_b, gv_b); end
        checks++; if (lg_a !== 8'd20) begin failures++; $display("FAIL sat_gap_wide got=%0d exp=20", lg_a); end
        drive(1, 1);
        checks++;
        if ({tc_a, wc_a, al_a, lg_a, gv_a, tc_b, wc_b, al_b, lg_b, gv_b} !== '0) begin
            failures++;
            $display("FAIL clr_priority got a=%0d/%0d/%0d/%0d/%0d b=%0d/%0d/%0d/%0d/%0d exp=all 0",
                     tc_a, wc_a, al_a, lg_a, gv_a, tc_b, wc_b, al_b, lg_b, gv_b);
        end
        drive(0, 0);
        checks++; if (tc_a !== 8'd0) begin failures++; $display("FAIL clr_hit_discarded got=%0d exp=0", tc_a); end
    endtask

    task automatic test_random();
        logic [22:0] ea;
        logic [13:0] eb;
        drive(0, 1);
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(99) < 25, $urandom_range(99) < 2);
            ea = {8'(f_tot(255)), 5'(f_win()), 1'(f_alarm()), 8'(f_gap(255)), 1'(f_gv())};
            eb = {2'(f_tot(3)),   5'(f_win()), 1'(f_alarm()), 3'(f_gap(7)),   1'(f_gv())};
            checks++;
            if ({tc_a, wc_a, al_a, lg_a, gv_a} !== ea) begin
                failures++;
                $display("FAIL rand_a n=%0d got=%h exp=%h", n, {tc_a, wc_a, al_a, lg_a, gv_a}, ea);
            end
            checks++;
            if ({tc_b, wc_b, al_b, lg_b, gv_b} !== eb) begin
                failures++;
                $display("FAIL rand_b n=%0d got=%h exp=%h", n, {tc_b, wc_b, al_b, lg_b, gv_b}, eb);
            end
        end
    endtask

    initial begin
        #12 reset = 1'b0;
        hits.delete(); cyc = 0;
        test_reset();
        test_gap();
        test_alarm();
        test_window();
        test_boundary();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
